// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types and constants for the alarm clock timekeeper.
//   - FSM state enum
//   - register addresses, time field widths and limits
//   - CONTROL bit indices
//   - hm_valid(): range check for an HH:MM register write
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_STATUS      = 3'd0;
  localparam logic [2:0] ADDR_CONTROL     = 3'd1;
  localparam logic [2:0] ADDR_TIME_HM     = 3'd2;
  localparam logic [2:0] ADDR_TIME_S      = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HM    = 3'd4;
  localparam logic [2:0] ADDR_SNOOZE_LEFT = 3'd5;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ALARM_EN = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_SNOOZE   = 3;
  localparam int CTRL_DISMISS  = 4;

  // HH:MM word layout: [12:8] hours, [5:0] minutes.
  function automatic logic hm_valid(input logic [15:0] d);
    return (d[12:8] <= MAX_HOUR) && (d[5:0] <= MAX_MIN);
  endfunction

endpackage

// File: rtl/alarm_clock_hms_counter.sv
// alarm_clock_hms_counter: prescaled HH:MM:SS time of day with load port.
//   clk, reset_n      : clock, async active-low reset
//   run, tick         : tick counts only while run=1
//   load_hm/load_s    : synchronous loads (already range-checked upstream)
//   load_hh/mm/ss     : load values
//   hh, mm, ss        : current time
//   sec_evt, min_evt  : one-cycle pulses, asserted in the cycle the new time
//                       is visible on hh/mm/ss
module alarm_clock_hms_counter
  import alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              tick,
  input  logic              load_hm,
  input  logic              load_s,
  input  logic [HOUR_W-1:0] load_hh,
  input  logic [MIN_W-1:0]  load_mm,
  input  logic [SEC_W-1:0]  load_ss,
  output logic [HOUR_W-1:0] hh,
  output logic [MIN_W-1:0]  mm,
  output logic [SEC_W-1:0]  ss,
  output logic              sec_evt,
  output logic              min_evt
);

  logic [15:0] presc;

  // Loads take priority over a coincident tick; that tick is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      hh      <= '0;
      mm      <= '0;
      ss      <= '0;
      sec_evt <= 1'b0;
      min_evt <= 1'b0;
    end else begin
      sec_evt <= 1'b0;
      min_evt <= 1'b0;
      if (load_hm) begin
        hh    <= load_hh;
        mm    <= load_mm;
        ss    <= '0;
        presc <= '0;
      end else if (load_s) begin
        ss    <= load_ss;
        presc <= '0;
      end else if (run && tick) begin
        if (presc == 16'(TICKS_PER_SEC - 1)) begin
          presc   <= '0;
          sec_evt <= 1'b1;
          if (ss == MAX_SEC) begin
            ss      <= '0;
            min_evt <= 1'b1;
            if (mm == MAX_MIN) begin
              mm <= '0;
              hh <= (hh == MAX_HOUR) ? '0 : hh + 1'b1;
            end else begin
              mm <= mm + 1'b1;
            end
          end else begin
            ss <= ss + 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_clock_timekeeper.sv
// alarm_clock_timekeeper: 24h clock + alarm with ring/snooze/dismiss FSM and
// a 16-bit Avalon-MM slave register file.
//   clk, reset_n                         : clock, async active-low reset
//   tick                                 : 1-cycle pulse from interval timer
//   address, chipselect, write_n,
//   writedata, readdata                  : Avalon-MM slave (readdata 1-cycle latency)
//   irq                                  : alarm_hit & irq_en (level)
//   buzzer                               : high while ringing
// Build option: define ALARM_CLOCK_BUZZER_PWM_EN to beep 1 s on / 1 s off
// while ringing instead of a steady buzzer.
module alarm_clock_timekeeper
  import alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 1,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        buzzer
);

  logic [2:0]        ctrl;
  logic [HOUR_W-1:0] alarm_hh, hh;
  logic [MIN_W-1:0]  alarm_mm, mm;
  logic [SEC_W-1:0]  ss;
  logic              sec_evt, min_evt;
  state_t            state;
  logic [15:0]       ring_cnt;
  logic [5:0]        snooze_left;
  logic              alarm_hit;
`ifdef ALARM_CLOCK_BUZZER_PWM_EN
  logic              phase;
`endif

  logic wr, status_wr, ctrl_wr, snooze_stb, dismiss_stb, load_hm, load_s;
  logic alarm_match;
  logic unused_wdata;

  assign wr          = chipselect & ~write_n;
  assign status_wr   = wr && (address == ADDR_STATUS);
  assign ctrl_wr     = wr && (address == ADDR_CONTROL);
  assign snooze_stb  = ctrl_wr && writedata[CTRL_SNOOZE];
  assign dismiss_stb = ctrl_wr && writedata[CTRL_DISMISS];
  assign load_hm     = wr && (address == ADDR_TIME_HM) && hm_valid(writedata);
  assign load_s      = wr && (address == ADDR_TIME_S) && (writedata[5:0] <= MAX_SEC);
  assign unused_wdata = ^{writedata[15:13], writedata[7:6]};

  // hh/mm already hold the freshly advanced time while min_evt is high.
  assign alarm_match = min_evt && (hh == alarm_hh) && (mm == alarm_mm);
  assign irq         = alarm_hit & ctrl[CTRL_IRQ_EN];

  alarm_clock_hms_counter #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_hms (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (ctrl[CTRL_RUN]),
    .tick    (tick),
    .load_hm (load_hm),
    .load_s  (load_s),
    .load_hh (writedata[12:8]),
    .load_mm (writedata[5:0]),
    .load_ss (writedata[5:0]),
    .hh      (hh),
    .mm      (mm),
    .ss      (ss),
    .sec_evt (sec_evt),
    .min_evt (min_evt)
  );

  // Register file and registered read mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      alarm_hh <= 5'd6;
      alarm_mm <= '0;
      readdata <= '0;
    end else begin
      if (ctrl_wr) ctrl <= writedata[2:0];
      if (wr && (address == ADDR_ALARM_HM) && hm_valid(writedata)) begin
        alarm_hh <= writedata[12:8];
        alarm_mm <= writedata[5:0];
      end
      case (address)
        ADDR_STATUS:      readdata <= {13'b0, state == ST_SNOOZE, state == ST_RINGING, alarm_hit};
        ADDR_CONTROL:     readdata <= {13'b0, ctrl};
        ADDR_TIME_HM:     readdata <= {3'b0, hh, 2'b0, mm};
        ADDR_TIME_S:      readdata <= {10'b0, ss};
        ADDR_ALARM_HM:    readdata <= {3'b0, alarm_hh, 2'b0, alarm_mm};
        ADDR_SNOOZE_LEFT: readdata <= {10'b0, snooze_left};
        default:          readdata <= '0;
      endcase
    end
  end

  // Ring/snooze FSM. buzzer is updated alongside every state change.
  // An alarm_hit set on RINGING entry overrides a same-cycle STATUS clear
  // because the set is the later assignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ring_cnt    <= '0;
      snooze_left <= '0;
      alarm_hit   <= 1'b0;
      buzzer      <= 1'b0;
`ifdef ALARM_CLOCK_BUZZER_PWM_EN
      phase       <= 1'b0;
`endif
    end else begin
      if (status_wr) alarm_hit <= 1'b0;
      if (!ctrl[CTRL_ALARM_EN]) begin
        state       <= ST_IDLE;
        snooze_left <= '0;
        buzzer      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (alarm_match) begin
            state     <= ST_RINGING;
            ring_cnt  <= '0;
            alarm_hit <= 1'b1;
            buzzer    <= 1'b1;
`ifdef ALARM_CLOCK_BUZZER_PWM_EN
            phase     <= 1'b1;
`endif
          end
          ST_RINGING: begin
            if (dismiss_stb) begin
              state  <= ST_IDLE;
              buzzer <= 1'b0;
            end else if (snooze_stb) begin
              state       <= ST_SNOOZE;
              snooze_left <= 6'(SNOOZE_MIN);
              buzzer      <= 1'b0;
            end else if (sec_evt) begin
              if (ring_cnt == 16'(RING_TIMEOUT_S - 1)) begin
                state  <= ST_IDLE;
                buzzer <= 1'b0;
              end else begin
                ring_cnt <= ring_cnt + 1'b1;
`ifdef ALARM_CLOCK_BUZZER_PWM_EN
                phase    <= ~phase;
                buzzer   <= ~phase;
`endif
              end
            end
          end
          ST_SNOOZE: begin
            if (dismiss_stb) begin
              state       <= ST_IDLE;
              snooze_left <= '0;
            end else if (min_evt) begin
              if (snooze_left == 6'd1) begin
                state       <= ST_RINGING;
                snooze_left <= '0;
                ring_cnt    <= '0;
                alarm_hit   <= 1'b1;
                buzzer      <= 1'b1;
`ifdef ALARM_CLOCK_BUZZER_PWM_EN
                phase       <= 1'b1;
`endif
              end else begin
                snooze_left <= snooze_left - 1'b1;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            buzzer <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
